// File: rtl/block_addr_pkg.sv
// ============================================================================
// block_addr_pkg : shared state encoding and default parameters for block_addr_seq
// Revision: 1.0
// ============================================================================
`default_nettype none

package block_addr_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned STRIDE_DEF = 16;
  localparam int unsigned CNT_W_DEF  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_e;

endpackage : block_addr_pkg

`default_nettype wire

// File: rtl/block_addr_seq.sv
// ============================================================================
// block_addr_seq : issues num_blocks block base addresses spaced by STRIDE over a
// valid/ready handshake. Optional BLOCK_ADDR_SEQ_ABORT_EN adds an abort input.
// Revision: 1.0
// ============================================================================
`default_nettype none

module block_addr_seq
  import block_addr_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned STRIDE = STRIDE_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  num_blocks,
  input  logic              ready,
`ifdef BLOCK_ADDR_SEQ_ABORT_EN
  input  logic              abort,
`endif
  output logic [ADDR_W-1:0] current_address,
  output logic              addr_valid,
  output logic [CNT_W-1:0]  block_idx,
  output logic              busy,
  output logic              done
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  last_q, last_d;
  logic              abort_req;

`ifdef BLOCK_ADDR_SEQ_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      idx_q   <= '0;
      last_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    idx_d   = idx_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (num_blocks != '0) begin
            state_d = RUN;
            addr_d  = base_addr;
            idx_d   = '0;
            // Storing the final index keeps the last-transfer compare a plain equality.
            last_d  = num_blocks - CNT_W'(1);
          end else begin
            state_d = FIN;
          end
        end
      end
      RUN: begin
        if (abort_req) begin
          state_d = FIN;
        end else if (ready) begin
          if (idx_q == last_q) begin
            state_d = FIN;
          end else begin
            addr_d = addr_q + ADDR_W'(STRIDE);
            idx_d  = idx_q + CNT_W'(1);
          end
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign current_address = addr_q;
  assign block_idx       = idx_q;
  assign addr_valid      = (state_q == RUN);
  assign busy            = (state_q != IDLE);
  assign done            = (state_q == FIN);

endmodule : block_addr_seq

`default_nettype wire

// File: tb/tb_block_addr_seq.sv
// ============================================================================
// tb_block_addr_seq : directed self-checking bench for block_addr_seq
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_block_addr_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] base_addr;
  logic [15:0] num_blocks;
  logic        ready;
`ifdef BLOCK_ADDR_SEQ_ABORT_EN
  logic        abort;
`endif
  logic [31:0] current_address;
  logic        addr_valid;
  logic [15:0] block_idx;
  logic        busy;
  logic        done;

  int vectors;
  int miscompares;

  block_addr_seq dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .base_addr       (base_addr),
    .num_blocks      (num_blocks),
    .ready           (ready),
`ifdef BLOCK_ADDR_SEQ_ABORT_EN
    .abort           (abort),
`endif
    .current_address (current_address),
    .addr_valid      (addr_valid),
    .block_idx       (block_idx),
    .busy            (busy),
    .done            (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // valid, address, index, busy, done
  task automatic check_all(input string tag, input logic v, input logic [31:0] a,
                           input logic [15:0] i, input logic b, input logic d);
    check({tag, ".valid"}, {31'd0, addr_valid}, {31'd0, v});
    check({tag, ".addr"},  current_address, a);
    check({tag, ".idx"},   {16'd0, block_idx}, {16'd0, i});
    check({tag, ".busy"},  {31'd0, busy}, {31'd0, b});
    check({tag, ".done"},  {31'd0, done}, {31'd0, d});
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    start       = 1'b0;
    base_addr   = 32'h0;
    num_blocks  = 16'd0;
    ready       = 1'b1;
`ifdef BLOCK_ADDR_SEQ_ABORT_EN
    abort       = 1'b0;
`endif

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check_all("reset", 1'b0, 32'h0, 16'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check_all("idle_ready_hi", 1'b0, 32'h0, 16'd0, 1'b0, 1'b0);

    // Basic run: 0x100, 3 blocks, ready tied high; inputs changed after capture
    base_addr = 32'h100; num_blocks = 16'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0; base_addr = 32'hDEAD_0000; num_blocks = 16'd9;
    check_all("t1_b0", 1'b1, 32'h100, 16'd0, 1'b1, 1'b0);
    start = 1'b1;  // ignored while running
    @(negedge clk);
    check_all("t1_b1", 1'b1, 32'h110, 16'd1, 1'b1, 1'b0);
    @(negedge clk);
    check_all("t1_b2", 1'b1, 32'h120, 16'd2, 1'b1, 1'b0);
    @(negedge clk);
    check_all("t1_fin", 1'b0, 32'h120, 16'd2, 1'b1, 1'b1);
    @(negedge clk);
    start = 1'b0;
    check_all("t1_idle", 1'b0, 32'h120, 16'd2, 1'b0, 1'b0);

    // Backpressure: ready low 4 cycles while block 1 is presented
    base_addr = 32'h100; num_blocks = 16'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_all("t2_b0", 1'b1, 32'h100, 16'd0, 1'b1, 1'b0);
    @(negedge clk);
    check_all("t2_b1", 1'b1, 32'h110, 16'd1, 1'b1, 1'b0);
    ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_all("t2_hold", 1'b1, 32'h110, 16'd1, 1'b1, 1'b0);
    end
    ready = 1'b1;
    @(negedge clk);
    check_all("t2_b2", 1'b1, 32'h120, 16'd2, 1'b1, 1'b0);
    @(negedge clk);
    check_all("t2_fin", 1'b0, 32'h120, 16'd2, 1'b1, 1'b1);
    @(negedge clk);
    check_all("t2_idle", 1'b0, 32'h120, 16'd2, 1'b0, 1'b0);

    // Zero blocks: straight to FIN
    base_addr = 32'h500; num_blocks = 16'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_all("t3_fin", 1'b0, 32'h120, 16'd2, 1'b1, 1'b1);
    @(negedge clk);
    check_all("t3_idle", 1'b0, 32'h120, 16'd2, 1'b0, 1'b0);

    // Address wrap at top of space
    base_addr = 32'hFFFF_FFF0; num_blocks = 16'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_all("t4_b0", 1'b1, 32'hFFFF_FFF0, 16'd0, 1'b1, 1'b0);
    @(negedge clk);
    check_all("t4_b1", 1'b1, 32'h0000_0000, 16'd1, 1'b1, 1'b0);
    @(negedge clk);
    check_all("t4_fin", 1'b0, 32'h0000_0000, 16'd1, 1'b1, 1'b1);
    @(negedge clk);

    // Reset during block 2 of 5
    base_addr = 32'h200; num_blocks = 16'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_all("t5_b0", 1'b1, 32'h200, 16'd0, 1'b1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check_all("t5_b2", 1'b1, 32'h220, 16'd2, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    check_all("t5_async_rst", 1'b0, 32'h0, 16'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    check_all("t5_in_rst", 1'b0, 32'h0, 16'd0, 1'b0, 1'b0);
    @(negedge clk);
    check_all("t5_after_rst", 1'b0, 32'h0, 16'd0, 1'b0, 1'b0);
    base_addr = 32'h300; num_blocks = 16'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_all("t5_fresh_b0", 1'b1, 32'h300, 16'd0, 1'b1, 1'b0);
    @(negedge clk);
    check_all("t5_fresh_fin", 1'b0, 32'h300, 16'd0, 1'b1, 1'b1);
    @(negedge clk);
    check_all("t5_fresh_idle", 1'b0, 32'h300, 16'd0, 1'b0, 1'b0);

`ifdef BLOCK_ADDR_SEQ_ABORT_EN
    // Abort while block 1 of 4 is presented
    base_addr = 32'h400; num_blocks = 16'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_all("t6_b0", 1'b1, 32'h400, 16'd0, 1'b1, 1'b0);
    @(negedge clk);
    check_all("t6_b1", 1'b1, 32'h410, 16'd1, 1'b1, 1'b0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("t6_fin.valid", {31'd0, addr_valid}, 32'd0);
    check("t6_fin.done",  {31'd0, done}, 32'd1);
    check("t6_fin.busy",  {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("t6_idle.valid", {31'd0, addr_valid}, 32'd0);
    check("t6_idle.done",  {31'd0, done}, 32'd0);
    check("t6_idle.busy",  {31'd0, busy}, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_block_addr_seq

`default_nettype wire
